// File: rtl/read_query_arbiter_if.sv
// Lane/RAM-side bundle of the shared base-query port of the read RAM.
// master: lanes + RAM (environment); slave: the arbiter.
interface read_query_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
);
    logic                 stall;
    logic [NUM_REQ-1:0]   req;
    logic [NUM_REQ*6-1:0] req_read_num;
    logic [NUM_REQ*7-1:0] req_position;
    logic [NUM_REQ-1:0]   gnt;
    logic [5:0]           ram_query_read_num;
    logic [6:0]           ram_query_position;
    logic [7:0]           ram_query_data;
    logic                 resp_valid;
    logic [ID_W-1:0]      resp_id;
    logic [7:0]           resp_data;
    logic [6:0]           resp_position;
    logic                 busy;

    modport master (
        output stall, req, req_read_num, req_position, ram_query_data,
        input  gnt, ram_query_read_num, ram_query_position,
        input  resp_valid, resp_id, resp_data, resp_position, busy
    );

    modport slave (
        input  stall, req, req_read_num, req_position, ram_query_data,
        output gnt, ram_query_read_num, ram_query_position,
        output resp_valid, resp_id, resp_data, resp_position, busy
    );
endinterface

// File: rtl/read_query_arbiter.sv
// Round-robin arbiter sharing the read RAM base-query port between lanes.
// Optional READ_QUERY_ARB_PERF_EN adds grant_cnt / oor_cnt saturating counters.
module read_query_arbiter #(
    parameter int         NUM_REQ  = 4,
    parameter int         ID_W     = 2,
    parameter int         RAM_LAT  = 4,
    parameter int         READ_LEN = 101,
    parameter logic [7:0] SENTINEL = 8'hFF
) (
    input  logic clk,
    input  logic reset,
    read_query_arbiter_if.slave bus
`ifdef READ_QUERY_ARB_PERF_EN
    ,
    output logic [NUM_REQ*16-1:0] grant_cnt,
    output logic [15:0]           oor_cnt
`endif
);

    logic [ID_W-1:0]    r_ptr;
    logic [RAM_LAT-1:0] r_vld;
    logic [RAM_LAT-1:0] r_oor;
    logic [ID_W-1:0]    r_id  [RAM_LAT];
    logic [6:0]         r_pos [RAM_LAT];

    logic [NUM_REQ-1:0] w_gnt;
    logic               w_gnt_any;
    logic [ID_W-1:0]    w_gnt_id;
    logic [ID_W-1:0]    w_idx;
    logic [5:0]         w_sel_rn;
    logic [6:0]         w_sel_pos;
    logic               w_oor;

    // Scan from the pointer upward; the first asserted request wins.
    always_comb begin
        w_gnt     = '0;
        w_gnt_any = 1'b0;
        w_gnt_id  = '0;
        w_idx     = '0;
        if (!reset && !bus.stall) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                w_idx = ID_W'((int'(r_ptr) + i) % NUM_REQ);
                if (!w_gnt_any && bus.req[w_idx]) begin
                    w_gnt_any    = 1'b1;
                    w_gnt_id     = w_idx;
                    w_gnt[w_idx] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_sel_rn  = '0;
        w_sel_pos = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gnt[i]) begin
                w_sel_rn  = bus.req_read_num[i*6 +: 6];
                w_sel_pos = bus.req_position[i*7 +: 7];
            end
        end
    end

    // Out-of-range queries still drive the RAM; their result is replaced downstream.
    assign w_oor = ({25'd0, w_sel_pos} >= 32'(READ_LEN));

    assign bus.gnt                = w_gnt;
    assign bus.ram_query_read_num = w_sel_rn;
    assign bus.ram_query_position = w_sel_pos;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr <= '0;
            r_vld <= '0;
        end else if (!bus.stall) begin
            r_vld[0] <= w_gnt_any;
            for (int i = 1; i < RAM_LAT; i++) begin
                r_vld[i] <= r_vld[i-1];
            end
            if (w_gnt_any) begin
                r_ptr <= (w_gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : w_gnt_id + ID_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!bus.stall) begin
            r_id[0]  <= w_gnt_id;
            r_pos[0] <= w_sel_pos;
            r_oor[0] <= w_oor;
            for (int i = 1; i < RAM_LAT; i++) begin
                r_id[i]  <= r_id[i-1];
                r_pos[i] <= r_pos[i-1];
                r_oor[i] <= r_oor[i-1];
            end
        end
    end

    // A stalled cycle holds the last stage, so gating by stall gives one pulse per query.
    assign bus.resp_valid    = r_vld[RAM_LAT-1] & ~bus.stall & ~reset;
    assign bus.resp_id       = r_id[RAM_LAT-1];
    assign bus.resp_position = r_pos[RAM_LAT-1];
    assign bus.resp_data     = r_oor[RAM_LAT-1] ? SENTINEL : bus.ram_query_data;
    assign bus.busy          = |r_vld;

`ifdef READ_QUERY_ARB_PERF_EN
    logic [15:0] r_grant_cnt [NUM_REQ];
    logic [15:0] r_oor_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                r_grant_cnt[i] <= '0;
            end
            r_oor_cnt <= '0;
        end else if (w_gnt_any) begin
            if (r_grant_cnt[w_gnt_id] != 16'hFFFF) begin
                r_grant_cnt[w_gnt_id] <= r_grant_cnt[w_gnt_id] + 16'd1;
            end
            if (w_oor && r_oor_cnt != 16'hFFFF) begin
                r_oor_cnt <= r_oor_cnt + 16'd1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            grant_cnt[i*16 +: 16] = r_grant_cnt[i];
        end
    end
    assign oor_cnt = r_oor_cnt;
`endif

endmodule
